// File: rtl/spi_pkg.sv
// Shared types for the SPI master: controller state encoding and SPI mode constants.
package spi_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    RESP
  } state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_ctrl_shift_reg.sv
// Parallel-load, left-shifting register holding outgoing bits (MSB first) and
// collecting incoming bits at the LSB end.
module ShiftReg
  import spi_pkg::*;
#(
  parameter int               nbits       = 32,
  parameter logic [nbits-1:0] reset_value = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [nbits-1:0] load_data,
  input  logic             shift_en,
  input  logic             in_,
  output logic [nbits-1:0] out
);

  // Reset here is active-high; the controller passes in its inverted reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= reset_value;
    end else if (load_en) begin
      out <= load_data;
    end else if (shift_en) begin
      out <= {out[nbits-2:0], in_};
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one full-duplex transfer of up to nbits bits per request.
// Build option SPI_MASTER_LOOPBACK_EN adds a loopback input that echoes mosi into the receive path.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int nbits       = 32,
  parameter int HALF_PERIOD = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [nbits-1:0]         req_msg,
  input  logic [$clog2(nbits):0]   packet_size,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [nbits-1:0]         resp_msg,
  output logic                     sclk,
  output logic                     cs_n,
  output logic                     mosi,
  input  logic                     miso
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic                     loopback
`endif
);

  localparam int CNT_W = $clog2(nbits) + 1;
  localparam int HP_W  = $clog2(HALF_PERIOD) + 1;
  localparam logic [CNT_W-1:0] NB      = CNT_W'(nbits);
  localparam logic [HP_W-1:0]  HP_LAST = HP_W'(HALF_PERIOD - 1);

  state_t             state;
  state_t             state_next;
  logic [HP_W-1:0]    hp_cnt;
  logic [CNT_W-1:0]   bits_left;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   n_eff;
  logic               miso_q;
  logic               rx_bit;
  logic               load_en;
  logic               shift_en;
  logic               sample_en;
  logic               hp_done;
  logic [nbits-1:0]   load_data;
  logic [nbits-1:0]   shreg;
  logic [nbits-1:0]   mask;

  // A size of zero or anything above nbits means a full-width transfer.
  always_comb begin
    n_eff = packet_size;
    if (packet_size == '0 || packet_size > NB) begin
      n_eff = NB;
    end
  end

  assign load_data = req_msg << (NB - n_eff);
  assign hp_done   = (hp_cnt == HP_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? mosi : miso;
`else
  assign rx_bit = miso;
`endif

  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    sample_en  = 1'b0;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    cs_n       = 1'b1;
    sclk       = SPI_CPOL;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          load_en    = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        cs_n = 1'b0;
        if (hp_done) begin
          sample_en  = 1'b1;
          state_next = HIGH;
        end
      end
      HIGH: begin
        cs_n = 1'b0;
        sclk = ~SPI_CPOL;
        if (hp_done) begin
          shift_en   = 1'b1;
          state_next = LOW;
        end
      end
      LOW: begin
        cs_n = 1'b0;
        if (hp_done) begin
          if (bits_left == '0) begin
            state_next = RESP;
          end else begin
            sample_en  = 1'b1;
            state_next = HIGH;
          end
        end
      end
      RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Pins and handshakes read idle for as long as reset is held.
    if (!reset) begin
      state_next = IDLE;
      load_en    = 1'b0;
      shift_en   = 1'b0;
      sample_en  = 1'b0;
      req_rdy    = 1'b0;
      resp_val   = 1'b0;
      cs_n       = 1'b1;
      sclk       = SPI_CPOL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      hp_cnt    <= '0;
      bits_left <= '0;
      n_q       <= '0;
      miso_q    <= 1'b0;
    end else begin
      state  <= state_next;
      hp_cnt <= (state_next != state) ? '0 : hp_cnt + 1'b1;
      if (load_en) begin
        bits_left <= n_eff;
        n_q       <= n_eff;
      end else if (shift_en) begin
        bits_left <= bits_left - 1'b1;
      end
      if (sample_en) begin
        miso_q <= rx_bit;
      end
    end
  end

  ShiftReg #(
    .nbits      (nbits),
    .reset_value('0)
  ) u_shift_reg (
    .clk      (clk),
    .reset    (~reset),
    .load_en  (load_en),
    .load_data(load_data),
    .shift_en (shift_en),
    .in_      (miso_q),
    .out      (shreg)
  );

  // Received bits sit right-justified; stale bits above N are cleared.
  always_comb begin
    mask = '1;
    if (n_q < NB) begin
      mask = (nbits'(1) << n_q) - nbits'(1);
    end
  end

  assign resp_msg = shreg & mask;
  assign mosi     = shreg[nbits-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (nbits=8, HALF_PERIOD=1) with a mode-0 slave model.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] req_msg;
  logic [3:0] packet_size;
  logic       resp_val;
  logic       resp_rdy;
  logic [7:0] resp_msg;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int         errors = 0;
  int         checks = 0;

  logic [7:0] slv_data  = 8'h00;
  int         slv_n     = 8;
  int         slv_idx   = -1;
  int         sclk_cnt  = 0;
  logic [7:0] mosi_cap  = 8'h00;
  logic       prev_cs_n = 1'b1;
  logic       prev_sclk = 1'b0;

  spi_master_ctrl #(
    .nbits      (8),
    .HALF_PERIOD(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_msg    (req_msg),
    .packet_size(packet_size),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_msg   (resp_msg),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso)
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    .loopback   (loopback)
`endif
  );

  always #5 clk = ~clk;

  // Slave model: presents its word MSB first, advancing on falling SCLK, and
  // records mosi and the pulse count at every rising SCLK.
  always @(posedge clk) begin
    #1;
    if (prev_cs_n && !cs_n) begin
      sclk_cnt = 0;
      mosi_cap = 8'h00;
      slv_idx  = slv_n - 1;
    end
    if (!prev_sclk && sclk) begin
      sclk_cnt = sclk_cnt + 1;
      mosi_cap = {mosi_cap[6:0], mosi};
    end
    if (prev_sclk && !sclk && !cs_n) begin
      slv_idx = slv_idx - 1;
    end
    miso      = (slv_idx >= 0 && slv_idx < 8) ? slv_data[slv_idx] : 1'b0;
    prev_cs_n = cs_n;
    prev_sclk = sclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge with the DUT idle; returns the cycle at which resp_val was seen.
  task automatic applyStimulus(input logic [7:0] msg, input logic [3:0] size,
                               input logic [7:0] sdata, input int sn,
                               input bit keep_val, output int cyc);
    slv_data    = sdata;
    slv_n       = sn;
    req_msg     = msg;
    packet_size = size;
    req_val     = 1'b1;
    cyc         = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!keep_val) req_val = 1'b0;
      if (resp_val) break;
    end
  endtask

  int  cyc;
  bit  saw_resp;

  initial begin
    reset       = 1'b0;
    req_val     = 1'b0;
    req_msg     = 8'h00;
    packet_size = 4'd0;
    resp_rdy    = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cs_n", cs_n, 1);
    checkOutput("rst_sclk", sclk, 0);
    checkOutput("rst_req_rdy", req_rdy, 0);
    checkOutput("rst_resp_val", resp_val, 0);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_resp_msg", resp_msg, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req_rdy", req_rdy, 1);
    checkOutput("post_rst_cs_n", cs_n, 1);

    // Full byte exchange.
    applyStimulus(8'hA5, 4'd8, 8'h3C, 8, 1'b0, cyc);
    checkOutput("a5_cycle", cyc, 18);
    checkOutput("a5_resp_msg", resp_msg, 8'h3C);
    checkOutput("a5_mosi_bits", mosi_cap, 8'hA5);
    checkOutput("a5_pulses", sclk_cnt, 8);
    @(negedge clk);
    checkOutput("a5_back_idle", req_rdy, 1);

    // Short packet, result right-justified.
    applyStimulus(8'h0B, 4'd4, 8'h09, 4, 1'b0, cyc);
    checkOutput("0b_cycle", cyc, 10);
    checkOutput("0b_resp_msg", resp_msg, 8'h09);
    checkOutput("0b_mosi_bits", mosi_cap, 8'h0B);
    checkOutput("0b_pulses", sclk_cnt, 4);
    @(negedge clk);
    checkOutput("0b_back_idle", req_rdy, 1);

    // Size 0 means full width; response stalled with a request pending.
    resp_rdy = 1'b0;
    applyStimulus(8'hFF, 4'd0, 8'h81, 8, 1'b1, cyc);
    checkOutput("sz0_cycle", cyc, 18);
    checkOutput("sz0_resp_msg", resp_msg, 8'h81);
    checkOutput("sz0_mosi_bits", mosi_cap, 8'hFF);
    checkOutput("sz0_pulses", sclk_cnt, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_resp_val", resp_val, 1);
      checkOutput("stall_resp_msg", resp_msg, 8'h81);
      checkOutput("stall_cs_n", cs_n, 1);
      checkOutput("stall_req_rdy", req_rdy, 0);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    checkOutput("hs_resp_val", resp_val, 0);
    checkOutput("hs_no_new_xfer", cs_n, 1);
    checkOutput("hs_req_rdy", req_rdy, 1);
    req_val = 1'b0;
    @(negedge clk);

    // Reset asserted during the third SCLK high phase.
    slv_data    = 8'h3C;
    slv_n       = 8;
    req_msg     = 8'h99;
    packet_size = 4'd8;
    req_val     = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      req_val = 1'b0;
      if (sclk_cnt == 3) break;
    end
    checkOutput("mid_third_pulse", sclk_cnt, 3);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_cs_n", cs_n, 1);
    checkOutput("mid_rst_sclk", sclk, 0);
    checkOutput("mid_rst_req_rdy", req_rdy, 0);
    checkOutput("mid_rst_resp_val", resp_val, 0);
    reset    = 1'b1;
    saw_resp = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (resp_val) saw_resp = 1'b1;
    end
    checkOutput("mid_rst_no_resp", saw_resp, 0);
    checkOutput("mid_rst_idle", req_rdy, 1);

    applyStimulus(8'h5A, 4'd8, 8'hC3, 8, 1'b0, cyc);
    checkOutput("5a_cycle", cyc, 18);
    checkOutput("5a_resp_msg", resp_msg, 8'hC3);
    checkOutput("5a_mosi_bits", mosi_cap, 8'h5A);
    @(negedge clk);

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    applyStimulus(8'h6E, 4'd8, 8'h00, 8, 1'b0, cyc);
    checkOutput("lb_cycle", cyc, 18);
    checkOutput("lb_resp_msg", resp_msg, 8'h6E);
    @(negedge clk);
    loopback = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master controller that sequences an nbits-wide shift register through one full-duplex SPI transfer per request. It accepts a transmit word on a val/rdy request interface and loads it MSB-aligned into the shift register. It then drives SCLK/CS_N (mode 0: CPOL=0, CPHA=0) for a programmable number of bits, and returns the received bits on a val/rdy response interface. It sits between the processor-side message interface and the off-chip SPI pins.

## Interface
- nbits, 32, transfer word width and maximum bits per transfer
- HALF_PERIOD, 1, clk cycles per SCLK half-period (≥1)
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- req_val  input  1  request valid
- req_rdy  output  1  request ready
- req_msg  input  nbits  transmit data, right-justified
- packet_size  input  $clog2(nbits)+1  bits to transfer, sampled with req_msg
- resp_val  output  1  response valid
- resp_rdy  input  1  response ready
- resp_msg  output  nbits  received data, right-justified, upper bits zero
- sclk  output  1  SPI clock
- cs_n  output  1  chip select, active low
- mosi  output  1  master out
- miso  input  1  master in

## Operation
- Effective bit count N = packet_size; 0 or >nbits → N = nbits.
- States: IDLE, SETUP, HIGH, LOW, RESP.
- IDLE: req_rdy=1, cs_n=1, sclk=0. On req_val&req_rdy: shift register load_en=1 with req_msg << (nbits−N); bits_left←N; → SETUP.
- SETUP: cs_n=0, sclk=0 for HALF_PERIOD cycles; → HIGH.
- Entry to HIGH (from SETUP or LOW): miso_q←miso (rising-edge sample). HIGH: sclk=1 for HALF_PERIOD cycles.
- HIGH→LOW transition cycle: shift_en=1 with in_=miso_q; bits_left−1.
- LOW: sclk=0 for HALF_PERIOD cycles; at end bits_left==0 → RESP, else → HIGH.
- mosi = shift register bit nbits−1 at all times; changes only on falling SCLK.
- RESP: cs_n=1, sclk=0, resp_val=1, resp_msg = shift reg masked to low N bits; on resp_rdy → IDLE.
- load_en and shift_en are never asserted in the same cycle.

## Timing
- Reset values: req_rdy=0 while reset=0, resp_val=0, cs_n=1, sclk=0, mosi=0, resp_msg=0; state IDLE from first cycle after release.
- Request accepted at cycle 0. resp_val rises at cycle HALF_PERIOD·(2N+1)+1. Example: HALF_PERIOD=1, N=8 → cycle 18.
- req_rdy is low from acceptance until the cycle after the response handshake. A new request cannot be accepted in the same cycle as resp_val&resp_rdy.
- resp_val/resp_msg are held stable while resp_rdy=0. Stall is unbounded.
- reset=0 mid-transfer: next cycle IDLE, cs_n=1, sclk=0, partial data discarded, no response.
- miso is sampled only at HIGH entry. Changes at other times are ignored.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined: adds input port loopback (1 bit). When loopback=1, miso_q samples mosi instead of miso, so resp_msg equals the low N bits of req_msg. loopback is sampled every cycle.
- Not defined: port absent; miso always used.

## Structure
- Package spi_pkg: state enum (IDLE, SETUP, HIGH, LOW, RESP), state width constant, SPI mode constants.
- One sub-module: ShiftReg (nbits, reset_value 0). load_en, shift_en and in_ are driven by this controller. Reset to the sub-module is the inverted active-low reset.
- Half-period counter, bits_left counter and miso_q register live in spi_master_ctrl.

## Test plan
Bench defaults: nbits=8, HALF_PERIOD=1.
- Reset held 0 for 3 cycles → cs_n=1, sclk=0, req_rdy=0, resp_val=0. Release → req_rdy=1 next cycle.
- Request 0xA5, size 8, slave model returns 0x3C:
  - mosi at each rising SCLK = 1,0,1,0,0,1,0,1
  - resp_val at cycle 18, resp_msg=0x3C
- Request 0x0B, size 4, slave returns 0x9:
  - 4 SCLK pulses, mosi=1,0,1,1
  - resp_msg=0x09, resp_val at cycle 10
- Size 0 with 0xFF → 8 SCLK pulses, response at cycle 18.
- resp_rdy low 5 cycles with req_val=1 → resp_val/resp_msg stable, cs_n=1, req_rdy=0, no new transfer starts.
- reset=0 after 3rd rising SCLK → IDLE, cs_n=1 next cycle, no response. Next request 0x5A (slave returns 0xC3) → resp_msg=0xC3.
- Loopback build, loopback=1, request 0x6E size 8 → resp_msg=0x6E.
